// File: rtl/blink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : blink_pkg
// Description : Shared state encoding and default widths for blink_sequencer.
// Revision    : 1.0
// ============================================================================
package blink_pkg;

   localparam int unsigned C_DEF_TIME_W = 3;
   localparam int unsigned C_DEF_REP_W  = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/blink_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : blink_sequencer_if
// Description : Control/status bundle between a requester and blink_sequencer.
// Revision    : 1.0
// ============================================================================
interface blink_sequencer_if
   import blink_pkg::*;
#(
   parameter int unsigned TIME_W = C_DEF_TIME_W,
   parameter int unsigned REP_W  = C_DEF_REP_W
);
   logic              i_start;
   logic [TIME_W-1:0] i_on_time;
   logic [TIME_W-1:0] i_off_time;
   logic [REP_W-1:0]  i_reps;
   logic              i_abort;
   logic              o_led;
   logic              o_busy;
   logic              o_done;
   logic [REP_W-1:0]  o_rep_cnt;

   modport master (
      output i_start, i_on_time, i_off_time, i_reps, i_abort,
      input  o_led, o_busy, o_done, o_rep_cnt
   );

   modport slave (
      input  i_start, i_on_time, i_off_time, i_reps, i_abort,
      output o_led, o_busy, o_done, o_rep_cnt
   );
endinterface
`default_nettype wire

// File: rtl/blink_timer.sv
`default_nettype none
// ============================================================================
// Module      : blink_timer
// Description : Loadable phase down-counter; expire marks the last phase cycle.
// Revision    : 1.0
// ============================================================================
module blink_timer
   import blink_pkg::*;
#(
   parameter int unsigned TIME_W = C_DEF_TIME_W
) (
   input  wire logic              i_clk,
   input  wire logic              i_rst,
   input  wire logic              i_load,
   input  wire logic [TIME_W-1:0] i_value,
   output logic                   o_expire
);
   logic [TIME_W-1:0] cnt_q, cnt_d;

   // Stops at zero instead of wrapping, so a zero-length load still yields one cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (i_load) begin
         cnt_d = i_value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TIME_W'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_expire = (cnt_q <= TIME_W'(1));
endmodule
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : blink_sequencer
// Description : Runs a programmed number of LED on/off blinks, then pulses done.
// Revision    : 1.0
// ============================================================================
module blink_sequencer
   import blink_pkg::*;
#(
   parameter int unsigned TIME_W = C_DEF_TIME_W,
   parameter int unsigned REP_W  = C_DEF_REP_W
) (
   input  wire logic         i_clk,
   input  wire logic         i_rst,
   blink_sequencer_if.slave  bus
);
   state_e            state_q, state_d;
   logic [TIME_W-1:0] on_q, on_d;
   logic [TIME_W-1:0] off_q, off_d;
   logic [REP_W-1:0]  reps_q, reps_d;
   logic [REP_W-1:0]  cnt_q, cnt_d;
   logic [REP_W-1:0]  w_cnt_inc;
   logic              w_last;
   logic              w_load;
   logic [TIME_W-1:0] w_load_val;
   logic              w_expire;

   blink_timer #(
      .TIME_W (TIME_W)
   ) u_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (w_load),
      .i_value  (w_load_val),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         on_q    <= '0;
         off_q   <= '0;
         reps_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         on_q    <= on_d;
         off_q   <= off_d;
         reps_q  <= reps_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      on_d       = on_q;
      off_d      = off_q;
      reps_d     = reps_q;
      cnt_d      = cnt_q;
      w_load     = 1'b0;
      w_load_val = on_q;
      w_cnt_inc  = (cnt_q == {REP_W{1'b1}}) ? cnt_q : cnt_q + REP_W'(1);
      w_last     = (w_cnt_inc == reps_q);

      case (state_q)
         S_IDLE: begin
            if (bus.i_start) begin
               on_d   = bus.i_on_time;
               off_d  = bus.i_off_time;
               reps_d = bus.i_reps;
               cnt_d  = '0;
               if (bus.i_reps != '0) begin
                  state_d    = S_ON;
                  w_load     = 1'b1;
                  w_load_val = bus.i_on_time;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ON: begin
            if (w_expire) begin
               if (off_q != '0) begin
                  state_d    = S_OFF;
                  w_load     = 1'b1;
                  w_load_val = off_q;
               end else begin
                  // Zero off-time: the blink completes at the end of its ON phase.
                  cnt_d = w_cnt_inc;
                  if (w_last) begin
                     state_d = S_DONE;
                  end else begin
                     w_load = 1'b1;
                  end
               end
            end
         end
         S_OFF: begin
            if (w_expire) begin
               cnt_d = w_cnt_inc;
               if (w_last) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ON;
                  w_load  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides everything, including a start seen in the same cycle.
      if (bus.i_abort) begin
         state_d = S_IDLE;
         on_d    = on_q;
         off_d   = off_q;
         reps_d  = reps_q;
         cnt_d   = cnt_q;
         w_load  = 1'b0;
      end
   end

   always_comb begin
      bus.o_led     = (state_q == S_ON);
      bus.o_busy    = (state_q == S_ON) || (state_q == S_OFF);
      bus.o_done    = (state_q == S_DONE);
      bus.o_rep_cnt = cnt_q;
   end
endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_blink_sequencer
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0
// ============================================================================
module tb_blink_sequencer;
   localparam int TW = 3;
   localparam int RW = 4;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   always #5 i_clk = ~i_clk;

   blink_sequencer_if #(.TIME_W(TW), .REP_W(RW)) bus ();

   blink_sequencer #(.TIME_W(TW), .REP_W(RW)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      int on;
      int off;
      int reps;
      int done_cyc;
      int led_cyc;
      int cnt;
   } vec_t;

   typedef struct {
      bit led;
      bit busy;
      bit done;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_in(input bit st, input int on, input int off, input int reps, input bit ab);
      bus.i_start    = st;
      bus.i_on_time  = TW'(on);
      bus.i_off_time = TW'(off);
      bus.i_reps     = RW'(reps);
      bus.i_abort    = ab;
   endtask

   function automatic logic [31:0] ldb();
      return 32'({bus.o_led, bus.o_busy, bus.o_done});
   endfunction

   // Expected output timeline of one whole sequence, derived from blink counts.
   task automatic build_seq(input int on, input int off, input int reps);
      exp_q.delete();
      for (int b = 0; b < reps; b++) begin
         for (int i = 0; i < ((on == 0) ? 1 : on); i++) exp_q.push_back('{1'b1, 1'b1, 1'b0, b});
         for (int i = 0; i < off; i++) exp_q.push_back('{1'b0, 1'b1, 1'b0, b});
      end
      exp_q.push_back('{1'b0, 1'b0, 1'b1, reps});
   endtask

   task automatic model_step(input bit st, input bit ab, input int on, input int off, input int reps);
      if (ab) begin
         exp_q.delete();
         cur = '{1'b0, 1'b0, 1'b0, cur.cnt};
      end else if (exp_q.size() == 0 && !cur.done && !cur.busy && st) begin
         build_seq(on, off, reps);
         cur = exp_q.pop_front();
      end else if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
      end else begin
         cur = '{1'b0, 1'b0, 1'b0, cur.cnt};
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int led_n, done_n, done_c;
      led_n = 0; done_n = 0; done_c = 0;
      set_in(1'b1, v.on, v.off, v.reps, 1'b0);
      for (int c = 1; c <= 260; c++) begin
         tick();
         if (c == 1) bus.i_start = 1'b0;
         led_n += int'(bus.o_led);
         if (bus.o_done) begin
            done_n++;
            if (done_c == 0) done_c = c;
         end
      end
      chk($sformatf("vec%0d done_cycle", idx), 32'(done_c), 32'(v.done_cyc));
      chk($sformatf("vec%0d led_cycles", idx), 32'(led_n), 32'(v.led_cyc));
      chk($sformatf("vec%0d done_pulses", idx), 32'(done_n), 32'd1);
      chk($sformatf("vec%0d rep_cnt", idx), 32'(bus.o_rep_cnt), 32'(v.cnt));
   endtask

   // on=3 off=2 reps=2; when noisy, a conflicting start is held through busy and DONE.
   task automatic run_p30(input bit noisy);
      logic [12:0] led_m, busy_m;
      led_m  = 13'h1CE;
      busy_m = 13'h7FE;
      set_in(1'b1, 3, 2, 2, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) begin
            if (noisy) set_in(1'b1, 7, 7, 15, 1'b0);
            else bus.i_start = 1'b0;
         end
         chk($sformatf("p30%s c%0d led/busy/done", noisy ? "n" : "", c), ldb(),
             32'({led_m[c], busy_m[c], (c == 11)}));
         if (c == 11) begin
            chk("p30 rep_cnt at done", 32'(bus.o_rep_cnt), 32'd2);
            bus.i_start = 1'b0;
         end
      end
      chk("p30 rep_cnt held", 32'(bus.o_rep_cnt), 32'd2);
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{3, 2, 2, 11, 6, 2};
      tbl[1] = '{2, 0, 3, 7, 6, 3};
      tbl[2] = '{3, 3, 0, 1, 0, 0};
      tbl[3] = '{0, 1, 15, 31, 15, 15};
      tbl[4] = '{1, 1, 1, 3, 1, 1};
      tbl[5] = '{7, 7, 15, 211, 105, 15};
      tbl[6] = '{0, 0, 5, 6, 5, 5};

      set_in(1'b0, 0, 0, 0, 1'b0);
      #1 i_rst = 1'b1;
      #1;
      chk("reset led/busy/done", ldb(), 32'd0);
      chk("reset rep_cnt", 32'(bus.o_rep_cnt), 32'd0);
      tick();
      i_rst = 1'b0;
      tick();
      chk("post-reset idle", ldb(), 32'd0);

      for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

      run_p30(1'b1);

      // Abort mid-OFF of the first blink; a second start during busy is ignored.
      begin
         int dn, bz;
         dn = 0; bz = 0;
         set_in(1'b1, 5, 5, 4, 1'b0);
         for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) bus.i_start = 1'b0;
            if (c == 3) set_in(1'b1, 1, 1, 1, 1'b0);
            if (c == 4) bus.i_start = 1'b0;
            if (c == 8) begin
               chk("abort pre state", ldb(), 32'b010);
               bus.i_abort = 1'b1;
            end
            if (c == 9) begin
               bus.i_abort = 1'b0;
               chk("abort idle", ldb(), 32'd0);
               chk("abort rep_cnt", 32'(bus.o_rep_cnt), 32'd0);
            end
            if (c >= 9) begin
               dn += int'(bus.o_done);
               bz += int'(bus.o_busy);
            end
         end
         chk("abort no done", 32'(dn), 32'd0);
         chk("abort stays idle", 32'(bz), 32'd0);
      end

      // Abort and start together in IDLE.
      set_in(1'b1, 2, 2, 2, 1'b1);
      tick();
      set_in(1'b0, 0, 0, 0, 1'b0);
      chk("abort+start no start", ldb(), 32'd0);
      tick();
      chk("abort+start still idle", ldb(), 32'd0);

      // Reset in the OFF phase of the second blink.
      set_in(1'b1, 3, 2, 2, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) bus.i_start = 1'b0;
      end
      chk("pre-reset in OFF", ldb(), 32'b010);
      chk("pre-reset rep_cnt", 32'(bus.o_rep_cnt), 32'd1);
      #2 i_rst = 1'b1;
      #1;
      chk("async reset outputs", ldb(), 32'd0);
      chk("async reset rep_cnt", 32'(bus.o_rep_cnt), 32'd0);
      tick();
      i_rst = 1'b0;
      run_p30(1'b0);

      // Randomized run against the timeline model.
      #2 i_rst = 1'b1;
      #2 i_rst = 1'b0;
      exp_q.delete();
      cur = '{1'b0, 1'b0, 1'b0, 0};
      for (int n = 0; n < 1500; n++) begin
         bit st, ab;
         int on, off, reps;
         st   = ($urandom % 4) == 0;
         ab   = ($urandom % 40) == 0;
         on   = int'($urandom % 8);
         off  = (($urandom % 3) == 0) ? 0 : int'($urandom % 8);
         reps = (($urandom % 5) == 0) ? int'($urandom % 16) : int'($urandom % 4);
         set_in(st, on, off, reps, ab);
         model_step(st, ab, on, off, reps);
         tick();
         chk($sformatf("rand%0d led/busy/done/cnt", n),
             32'({bus.o_led, bus.o_busy, bus.o_done, bus.o_rep_cnt}),
             32'({cur.led, cur.busy, cur.done, 4'(cur.cnt)}));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 Parameter TIME_W, default 3, SHALL set the width of the phase-duration inputs in clock cycles.
REQ-002 Parameter REP_W, default 4, SHALL set the width of the blink-count input and the progress output.
REQ-003 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 i_start  input  1  SHALL request a sequence; sampled only in IDLE.
REQ-006 i_on_time  input  TIME_W  SHALL give the LED-on phase length in cycles; latched on accepted start.
REQ-007 i_off_time  input  TIME_W  SHALL give the LED-off phase length in cycles; latched on accepted start.
REQ-008 i_reps  input  REP_W  SHALL give the number of on/off blinks; latched on accepted start.
REQ-009 i_abort  input  1  SHALL cancel any sequence in progress.
REQ-010 o_led  output  1  SHALL drive the LED; high only in ON state.
REQ-011 o_busy  output  1  SHALL be high while in ON or OFF state.
REQ-012 o_done  output  1  SHALL pulse high for one cycle when a sequence completes normally.
REQ-013 o_rep_cnt  output  REP_W  SHALL report the number of completed blinks in the current or last sequence.

Function
REQ-014 FSM states SHALL be IDLE, ON, OFF, DONE; all outputs SHALL be registered or decoded from registered state.
REQ-015 IDLE with i_start=1 and i_reps!=0 at edge k SHALL latch parameters, clear o_rep_cnt, and enter ON at k+1.
REQ-016 IDLE with i_start=1 and i_reps=0 SHALL enter DONE (o_done pulse at k+1, o_led never high).
REQ-017 A phase with programmed length N SHALL last exactly N cycles; ON with N=0 SHALL last 1 cycle.
REQ-018 OFF with off_time=0 SHALL be skipped: ON goes directly to the next ON or to DONE.
REQ-019 At the end of each OFF phase (or ON phase when OFF is skipped) o_rep_cnt SHALL increment by one.
REQ-020 When o_rep_cnt reaches the latched reps, FSM SHALL enter DONE for exactly one cycle, then IDLE.
REQ-021 i_start while ON, OFF or DONE SHALL be ignored; latched parameters SHALL not change mid-sequence.
REQ-022 i_abort=1 in any state SHALL force IDLE at the next edge: o_led=0, o_busy=0, no o_done pulse, o_rep_cnt held.
REQ-023 i_abort and i_start both high in IDLE: abort SHALL win, no sequence starts.
REQ-024 Phase timing SHALL use a loadable down-counter of TIME_W bits; no wrap-around SHALL occur (reloaded on every phase entry).
REQ-025 o_rep_cnt SHALL saturate at 2^REP_W-1 and never wrap.

Reset
REQ-026 i_rst=1 SHALL asynchronously force state IDLE, o_led=0, o_busy=0, o_done=0, o_rep_cnt=0, timer=0, latched parameters=0.
REQ-027 Reset asserted mid-sequence SHALL abort without an o_done pulse; first start is accepted on the first edge after deassertion.

Structure
REQ-028 Package blink_pkg SHALL hold the state enum typedef and default TIME_W/REP_W constants.
REQ-029 Sub-module blink_timer SHALL implement the loadable down-counter (inputs load, value; output expire) used for both phases.

Verification
REQ-030 on=3, off=2, reps=2, start at edge 0 -> o_led high cycles 1-3 and 6-8, low 4-5 and 9-10, o_done pulse cycle 11, o_rep_cnt=2.
REQ-031 on=2, off=0, reps=3 -> o_led high cycles 1-6 continuously, o_done at cycle 7, o_rep_cnt=3.
REQ-032 reps=0 with start -> o_done pulse at cycle 1, o_led and o_busy stay 0.
REQ-033 on=5, off=5, reps=4; i_abort at cycle 8 -> IDLE at cycle 9, o_led=0, no o_done, o_rep_cnt=0; second start during busy ignored.
REQ-034 i_rst asserted mid-OFF phase -> outputs zero immediately (before next edge); new start after release behaves per REQ-030.
REQ-035 on=0, off=1, reps=15 -> 1-cycle ON / 1-cycle OFF for 15 blinks, o_rep_cnt=15, single o_done pulse.
